// File: rtl/sdram_init_seq.sv
// sdram_init_seq
// Power-up initialisation sequencer for the SDRAM command bus. After reset it
// waits T_PWRUP clocks, issues PRECHARGE-ALL, NUM_REFRESH AUTO-REFRESH
// commands spaced T_RFC apart, and a LOAD MODE REGISTER, then raises
// sdr_init_done. While done, an init_req pulse reruns the sequence from
// PRECHARGE without the power-up wait.
//
// Ports
//   sdram_clk      : clock, rising edge
//   sdram_resetn   : synchronous active-low reset
//   cfg_mode_reg   : mode register value, sampled on the edge that issues LMR
//   init_req       : re-initialisation request, honoured only while done
//   sdr_cke        : clock enable (low only while in reset)
//   sdr_cs_n/ras_n/cas_n/we_n : command pins, IDLE = 1111
//   sdr_addr/sdr_ba: address and bank buses
//   sdr_init_done  : high while initialisation is complete
module sdram_init_seq #(
  parameter int SDR_AW      = 13,
  parameter int SDR_BW      = 2,
  parameter int T_PWRUP     = 100,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 8,
  parameter int NUM_REFRESH = 8,
  parameter int T_MRD       = 2
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [SDR_AW-1:0] cfg_mode_reg,
  input  logic              init_req,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic [SDR_BW-1:0] sdr_ba,
  output logic              sdr_init_done
);

  localparam int MAX_A = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
  localparam int MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int RW    = $clog2(NUM_REFRESH) + 1;

  localparam logic [3:0] CMD_IDLE = 4'b1111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [3:0] {
    S_RST, S_PWRUP, S_PRE, S_WRP, S_REF, S_WRFC, S_LMR, S_WMRD, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [RW-1:0]     ref_cnt, ref_nxt;
  logic [3:0]        cmd_nxt;
  logic [SDR_AW-1:0] addr_nxt;
  logic              done_nxt;
  logic              more_refresh;

  // ref_cnt already includes the REFRESH just issued
  assign more_refresh = (ref_cnt < RW'(NUM_REFRESH));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ref_nxt   = ref_cnt;
    case (state)
      S_RST: begin
        state_nxt = S_PWRUP;
        cnt_nxt   = CW'(T_PWRUP - 1);
      end
      S_PWRUP: begin
        if (cnt == '0) state_nxt = S_PRE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_nxt = S_WRP;
          cnt_nxt   = CW'(T_RP - 2);
        end else begin
          state_nxt = S_REF;
        end
      end
      S_WRP: begin
        if (cnt == '0) state_nxt = S_REF;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_nxt = S_WRFC;
          cnt_nxt   = CW'(T_RFC - 2);
        end else begin
          state_nxt = more_refresh ? S_REF : S_LMR;
        end
      end
      S_WRFC: begin
        if (cnt == '0) state_nxt = more_refresh ? S_REF : S_LMR;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_LMR: begin
        if (T_MRD > 1) begin
          state_nxt = S_WMRD;
          cnt_nxt   = CW'(T_MRD - 2);
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_WMRD: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_DONE: begin
        // Re-init reuses PWRUP with a zero count: one idle cycle with done
        // low, then PRECHARGE, and CKE never drops.
        if (init_req) begin
          state_nxt = S_PWRUP;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = S_RST;
    endcase

    if (state_nxt == S_PRE) ref_nxt = '0;
    if (state_nxt == S_REF) ref_nxt = ref_cnt + 1'b1;
  end

  // Outputs are decoded from the next state and registered, so every pin
  // reflects the state entered on the same edge.
  always_comb begin
    cmd_nxt  = CMD_IDLE;
    addr_nxt = '0;
    case (state_nxt)
      S_PRE: begin
        cmd_nxt      = CMD_PRE;
        addr_nxt[10] = 1'b1;
      end
      S_REF:   cmd_nxt = CMD_REF;
      S_LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = cfg_mode_reg;
      end
      default: cmd_nxt = CMD_IDLE;
    endcase
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      state         <= S_RST;
      cnt           <= '0;
      ref_cnt       <= '0;
      sdr_cke       <= 1'b0;
      sdr_cs_n      <= 1'b1;
      sdr_ras_n     <= 1'b1;
      sdr_cas_n     <= 1'b1;
      sdr_we_n      <= 1'b1;
      sdr_addr      <= '0;
      sdr_ba        <= '0;
      sdr_init_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ref_cnt       <= ref_nxt;
      sdr_cke       <= 1'b1;
      sdr_cs_n      <= cmd_nxt[3];
      sdr_ras_n     <= cmd_nxt[2];
      sdr_cas_n     <= cmd_nxt[1];
      sdr_we_n      <= cmd_nxt[0];
      sdr_addr      <= addr_nxt;
      sdr_ba        <= '0;
      sdr_init_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
module tb_sdram_init_seq;

  localparam int AW    = 13;
  localparam int BW    = 2;
  localparam int TRP   = 2;
  localparam int TRFC  = 8;
  localparam int NREF  = 8;
  localparam int TMRD  = 2;
  localparam int NEVER = 1 << 30;

  logic          clk;
  logic          resetn;
  logic          init_req;
  logic [AW-1:0] cfg;

  logic          cke, cs_n, ras_n, cas_n, we_n, done;
  logic [AW-1:0] addr;
  logic [BW-1:0] ba;

  logic          c1_cke, c1_cs_n, c1_ras_n, c1_cas_n, c1_we_n, c1_done;
  logic [AW-1:0] c1_addr;
  logic [BW-1:0] c1_ba;

  sdram_init_seq dut (
    .sdram_clk(clk), .sdram_resetn(resetn), .cfg_mode_reg(cfg), .init_req(init_req),
    .sdr_cke(cke), .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n),
    .sdr_we_n(we_n), .sdr_addr(addr), .sdr_ba(ba), .sdr_init_done(done)
  );

  sdram_init_seq #(
    .T_PWRUP(1), .T_RP(1), .T_RFC(1), .NUM_REFRESH(1), .T_MRD(1)
  ) dut_min (
    .sdram_clk(clk), .sdram_resetn(resetn), .cfg_mode_reg(cfg), .init_req(init_req),
    .sdr_cke(c1_cke), .sdr_cs_n(c1_cs_n), .sdr_ras_n(c1_ras_n), .sdr_cas_n(c1_cas_n),
    .sdr_we_n(c1_we_n), .sdr_addr(c1_addr), .sdr_ba(c1_ba), .sdr_init_done(c1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rs_q = 1'b0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rs_q <= resetn;
  end

  typedef struct {
    int            cyc;
    logic [3:0]    cmd;
    logic [AW-1:0] addr;
    logic          done;
  } ev_t;

  ev_t  q[$];
  ev_t  e_cur;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic prev_done = 1'b0;
  logic [3:0] cmd_now;

  task automatic push(input int c, input logic [3:0] cm, input logic [AW-1:0] a, input logic d);
    ev_t e;
    e.cyc = c; e.cmd = cm; e.addr = a; e.done = d;
    q.push_back(e);
  endtask

  // Expected command stream of one init pass, PRECHARGE at edge pre;
  // events at or beyond edge lim are dropped (sequence cut by reset).
  task automatic push_seq(input int pre, input int lim, input logic [AW-1:0] mode);
    int c;
    if (pre < lim) push(pre, 4'b0010, 13'h400, 1'b0);
    for (int i = 0; i < NREF; i++) begin
      c = pre + TRP + i * TRFC;
      if (c < lim) push(c, 4'b0001, '0, 1'b0);
    end
    c = pre + TRP + NREF * TRFC;
    if (c < lim) push(c, 4'b0000, mode, 1'b0);
    if (c + TMRD < lim) push(c + TMRD, 4'b1111, '0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_req(input int r);
    wait_to(r - 1);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cke"},  {31'd0, cke}, 32'd0);
    chk({tag, "_cmd"},  {28'd0, cs_n, ras_n, cas_n, we_n}, 32'hF);
    chk({tag, "_addr"}, {19'd0, addr}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // Monitor: every non-IDLE command or done transition pops one expected event
  always @(negedge clk) begin
    if (mon_en) begin
      cmd_now = {cs_n, ras_n, cas_n, we_n};
      n_vec++;
      if (cke !== rs_q) begin
        n_err++;
        $display("FAIL cke @edge %0d: got %b want %b", cyc, cke, rs_q);
      end
      if (cmd_now != 4'hF || done !== prev_done) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event @edge %0d: cmd=%b addr=%h done=%b", cyc, cmd_now, addr, done);
        end else begin
          e_cur = q.pop_front();
          if (e_cur.cyc != cyc || e_cur.cmd !== cmd_now || e_cur.addr !== addr ||
              ba !== '0 || e_cur.done !== done) begin
            n_err++;
            $display("FAIL event: got edge=%0d cmd=%b addr=%h ba=%h done=%b, want edge=%0d cmd=%b addr=%h ba=0 done=%b",
                     cyc, cmd_now, addr, ba, done, e_cur.cyc, e_cur.cmd, e_cur.addr, e_cur.done);
          end
        end
      end else begin
        n_vec++;
        if (addr !== '0 || ba !== '0) begin
          n_err++;
          $display("FAIL idle_bus @edge %0d: got addr=%h ba=%h want 0/0", cyc, addr, ba);
        end
      end
      prev_done = done;
    end
  end

  logic [3:0]    min_cmd  [5] = '{4'hF, 4'b0010, 4'b0001, 4'b0000, 4'hF};
  logic [AW-1:0] min_addr [5] = '{13'h0, 13'h400, 13'h0, 13'h033, 13'h0};
  logic          min_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int e0, r, e0b, e0c;

  initial begin
    resetn   = 1'b0;
    init_req = 1'b0;
    cfg      = 13'h033;
    repeat (5) @(negedge clk);
    chk_reset_vals("rst0");
    mon_en = 1'b1;

    // Run 1: defaults, with ignored init_req pulses mid-sequence
    resetn = 1'b1;
    e0 = cyc + 1;
    push_seq(e0 + 100, NEVER, 13'h033);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("min_cke_%0d", k),  {31'd0, c1_cke}, 32'd1);
      chk($sformatf("min_cmd_%0d", k),  {28'd0, c1_cs_n, c1_ras_n, c1_cas_n, c1_we_n}, {28'd0, min_cmd[k]});
      chk($sformatf("min_addr_%0d", k), {19'd0, c1_addr}, {19'd0, min_addr[k]});
      chk($sformatf("min_done_%0d", k), {31'd0, c1_done}, {31'd0, min_done[k]});
    end

    pulse_req(e0 + 50);
    pulse_req(e0 + 140);
    wait_to(e0 + 166);
    cfg = 13'h111;
    wait_to(e0 + 167);
    chk("lmr_next_addr", {19'd0, addr}, 32'd0);
    wait_to(e0 + 170);
    chk("done_held", {31'd0, done}, 32'd1);

    // Re-init from DONE
    r = e0 + 178;
    push(r, 4'hF, '0, 1'b0);
    push_seq(r + 1, NEVER, 13'h111);
    pulse_req(r);
    wait_to(r + 75);

    // Reset while done, then a run cut mid-refresh by reset
    resetn = 1'b0;
    push(cyc + 1, 4'hF, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst1");
    resetn = 1'b1;
    e0b = cyc + 1;
    push_seq(e0b + 100, e0b + 130, 13'h111);
    wait_to(e0b + 129);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_mid");
    resetn = 1'b1;
    e0c = cyc + 1;
    push_seq(e0c + 100, NEVER, 13'h111);
    wait_to(e0c + 180);

    chk("events_pending", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
